reg_file_mp: RTL

- Parametrised next-generation integer register file for the RISC-V core.
- Two combinational read ports and two synchronous write ports: port 0 carries ALU/jump writeback, port 1 carries late load writeback.
- Optional write-to-read bypass and hardwired-zero x0.
- A per-register busy scoreboard tracks outstanding loads so the decode stage can stall on a RAW hazard.

---
 rtl/reg_file_mp.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Integer register file: two combinational read ports, two synchronous write
// ports (port 1 = load return, wins collisions), optional bypass and x0, plus
// a per-register load-pending scoreboard for RAW stall detection.
module reg_file_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] DataA,
  output logic [XLEN-1:0] DataB,
  input  logic            wen0,
  input  logic [AW-1:0]   rd0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            wen1,
  input  logic [AW-1:0]   rd1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_rd,
  output logic            busyA,
  output logic            busyB
);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic             wr0_s;
  logic             wr1_s;
  logic             set_s;
  logic [XLEN-1:0]  data_a_s;
  logic [XLEN-1:0]  data_b_s;
  logic             busy_a_s;
  logic             busy_b_s;

  // An index is usable when it names an implemented register other than a hardwired x0.
  function automatic logic legal_idx(input logic [AW-1:0] idx);
    if (int'(idx) >= NREGS) begin
      return 1'b0;
    end else if (ZERO_X0 && (idx == {AW{1'b0}})) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

  function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] rs);
    logic [XLEN-1:0] val;
    val = {XLEN{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      if (rs == AW'(i)) begin
        val = regs_r[i];
      end else begin
        val = val;
      end
    end
    // Port 1 takes priority in the bypass just as it does in the array.
    if (!legal_idx(rs)) begin
      val = {XLEN{1'b0}};
    end else if (BYPASS && wr1_s && (rd1 == rs)) begin
      val = wdata1;
    end else if (BYPASS && wr0_s && (rd0 == rs)) begin
      val = wdata0;
    end else begin
      val = val;
    end
    return val;
  endfunction

  function automatic logic read_busy(input logic [AW-1:0] rs);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rs == AW'(i)) begin
        b = busy_r[i];
      end else begin
        b = b;
      end
    end
    // A load returning this cycle is consumed through the bypass, so no stall.
    if (!legal_idx(rs)) begin
      b = 1'b0;
    end else if (BYPASS && wr1_s && (rd1 == rs)) begin
      b = 1'b0;
    end else begin
      b = b;
    end
    return b;
  endfunction

  assign wr0_s = wen0 && legal_idx(rd0);
  assign wr1_s = wen1 && legal_idx(rd1);
  assign set_s = busy_set && legal_idx(busy_rd);

  // Register array and scoreboard update; a re-issued load's set beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      busy_r <= {NREGS{1'b0}};
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr1_s && (rd1 == AW'(i))) begin
          regs_r[i] <= wdata1;
        end else if (wr0_s && (rd0 == AW'(i))) begin
          regs_r[i] <= wdata0;
        end else begin
          regs_r[i] <= regs_r[i];
        end
        if (set_s && (busy_rd == AW'(i))) begin
          busy_r[i] <= 1'b1;
        end else if (wr1_s && (rd1 == AW'(i))) begin
          busy_r[i] <= 1'b0;
        end else begin
          busy_r[i] <= busy_r[i];
        end
      end
    end
  end

  // Read ports; outputs are forced low while reset is asserted.
  always_comb begin
    data_a_s = read_data(rs1);
    data_b_s = read_data(rs2);
    busy_a_s = read_busy(rs1);
    busy_b_s = read_busy(rs2);
    if (!rst_n) begin
      DataA = {XLEN{1'b0}};
      DataB = {XLEN{1'b0}};
      busyA = 1'b0;
      busyB = 1'b0;
    end else begin
      DataA = data_a_s;
      DataB = data_b_s;
      busyA = busy_a_s;
      busyB = busy_b_s;
    end
  end

endmodule
